// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator for the asynchronous FIFO.
// Optional fill level / almost-full outputs are built when FIFO_WPTR_AFULL_EN is defined.
module fifo_wptr_full #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              wen,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull
`ifdef FIFO_WPTR_AFULL_EN
  ,
  output logic [ADDR_W:0]   wlevel,
  output logic              walmost_full
`endif
);

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic            wfull_q, wfull_d;

  // Full when the next write pointer has lapped the read pointer: in Gray code
  // that means the top two bits differ and all lower bits match.
  always_comb begin
    wen     = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wen};
    wptr_d  = (wbin_d >> 1) ^ wbin_d;
    wfull_d = (wptr_d == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
    end
  end

  assign waddr = wbin_q[ADDR_W-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;

`ifdef FIFO_WPTR_AFULL_EN
  localparam logic [ADDR_W:0] AFULL_LIMIT = (ADDR_W+1)'((2 ** ADDR_W) - AFULL_THRESH);

  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] wlevel_q, wlevel_d;
  logic            walmost_full_q, walmost_full_d;

  // The synchronized read pointer lags, so level and almost-full overestimate fill.
  always_comb begin
    rbin_s = wq2_rptr;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
    end
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= AFULL_LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wlevel_q       <= wlevel_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = walmost_full_q;
`endif

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and full-flag generator for the project's asynchronous FIFO. It keeps the binary write count, drives the RAM write address and write enable, and publishes a registered Gray-coded write pointer that feeds the two-flop synchronizer into the read domain. It computes `wfull` by comparing its next Gray pointer against the read pointer, which arrives already synchronized into this clock domain by a two-flop synchronizer.

## Interface
- `ADDR_W`, 4, RAM address width; FIFO depth = 2^ADDR_W.
- `AFULL_THRESH`, 2, free-slot count at or below which `walmost_full` asserts (only with `FIFO_WPTR_AFULL_EN`).

- `clk`  input  1  write-domain clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `winc`  input  1  write request from the producer.
- `wq2_rptr`  input  ADDR_W+1  read pointer, Gray code, already synchronized into `clk` domain.
- `waddr`  output  ADDR_W  binary RAM write address.
- `wen`  output  1  RAM write enable, = `winc & ~wfull` (combinational).
- `wptr`  output  ADDR_W+1  registered Gray write pointer, to the read-domain synchronizer.
- `wfull`  output  1  registered full flag.
- `wlevel`  output  ADDR_W+1  registered fill estimate (only with `FIFO_WPTR_AFULL_EN`).
- `walmost_full`  output  1  registered almost-full flag (only with `FIFO_WPTR_AFULL_EN`).

## Operation
- State: `wbin` (ADDR_W+1-bit binary count), `wptr`, `wfull`, plus `wlevel` and `walmost_full` when enabled.
- `wbin_next = wbin + wen`; modulo 2^(ADDR_W+1) wrap, no saturation.
- `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- `wfull_next = (wgray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]})`.
- Each edge: `wbin <= wbin_next`, `wptr <= wgray_next`, `wfull <= wfull_next`.
- `waddr = wbin[ADDR_W-1:0]`. It addresses the slot the current `wen` writes.
- A write while `wfull`=1 is dropped: `wen`=0, and `wbin` and `wptr` hold.
- No FSM. The only states are the count and the flags.
- `wptr` changes by at most one bit per cycle, including across the 2^(ADDR_W+1) wrap. It is always a flop output and never combinational.
- Reset (`rst`=0, asynchronous): `wbin`=0, `wptr`=0, `wfull`=0, `wlevel`=0, `walmost_full`=0. This applies immediately, regardless of `clk`. Asserting it mid-burst discards the count.

## Timing
- `waddr` and `wen` apply to the current cycle. Data is written on the same edge that advances `wbin`.
- `wfull` rises on the edge that performs the write filling the last slot. The next cycle's `wen` is already blocked.
- `wfull` falls on the first edge after `wq2_rptr` reflects a read. That is one cycle after the synchronizer output changes, and roughly 3 `clk` after the read-domain pointer moves. This is a pessimistic, safe delay.
- The `wq2_rptr` update and a write in the same cycle are both evaluated from `wbin_next`. No priority is needed.
- `wptr` reflects a write one edge after `wen`, plus two read-domain edges in the synchronizer.

## Configuration
- `FIFO_WPTR_AFULL_EN` defined:
  - Convert `wq2_rptr` Gray→binary as `rbin_s`.
  - `wlevel <= wbin_next - rbin_s` (mod 2^(ADDR_W+1)).
  - `walmost_full <= (wbin_next - rbin_s) >= 2^ADDR_W - AFULL_THRESH`.
  - Both flags are registered and pessimistic, because `rbin_s` lags.
- `FIFO_WPTR_AFULL_EN` undefined: `wlevel`, `walmost_full`, the Gray→binary converter and the subtractor are absent from the port list and logic.

## Test plan
- Reset: with `ADDR_W`=4, write 5 words, then pull `rst` low between clock edges. Required: all outputs 0 immediately. After release, `waddr`=0 and `wptr`=5'b00000.
- Fill: hold `wq2_rptr`=0 and drive `winc`=1 for 16 cycles. Required: `wfull`=1 after the 16th edge, with `waddr`=0 and `wptr`=5'b11000.
- Overflow: apply a 17th `winc` while full. Required: `wen`=0, and `wptr` stays 5'b11000 and `waddr` stays 0.
- Drain by one: set `wq2_rptr`=5'b00001. Required: `wfull`=0 after the next edge. Then write once. Required: `wptr`=5'b11001 and `wfull`=1.
- Wrap: run 32 writes with `wq2_rptr` tracking so the FIFO is never full. Required: `waddr` goes 15→0, `wptr` returns to 5'b00000, and a checker sees exactly one `wptr` bit change per write.
- Macro on, `AFULL_THRESH`=2: hold `wq2_rptr`=0 and make 13 writes. Required: `walmost_full`=0 and `wlevel`=13. On the 14th write, `walmost_full`=1 and `wlevel`=14.
